// File: rtl/core_pkg.sv
// Shared definitions for the MIPS-style core.
// Contents:
//   - instruction field slice positions (OP, SRC1, SRC2, DEST, IMM)
//   - HALT_WORD, the all-zero word that ends instruction fetch
//   - fetch_state_t, the state encoding of the fetch front end
package core_pkg;

    localparam int OP_MSB   = 31;
    localparam int OP_LSB   = 26;
    localparam int SRC1_MSB = 25;
    localparam int SRC1_LSB = 21;
    localparam int SRC2_MSB = 20;
    localparam int SRC2_LSB = 16;
    localparam int DEST_MSB = 15;
    localparam int DEST_LSB = 11;
    localparam int IMM_MSB  = 10;
    localparam int IMM_LSB  = 0;

    localparam logic [31:0] HALT_WORD = 32'h0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle of the instruction fetch unit.
// Groups the instruction-memory read port, the {pc, instr} valid/ready
// output stream and the redirect request from decode.
//   master : the fetch unit (drives imem_en/addr and the output stream)
//   slave  : the environment (memory, decode/execute, branch resolution)
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              imem_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_instr;
    logic [ADDR_W-1:0] out_pc;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;

    modport master (
        output imem_en, imem_addr, out_valid, out_instr, out_pc,
        input  imem_rdata, out_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_en, imem_addr, out_valid, out_instr, out_pc,
        output imem_rdata, out_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO buffering fetched {pc, instr} pairs.
// Ports:
//   clock, reset   clock and asynchronous active-high reset
//   i_flush        drop all entries (overrides push and pop)
//   i_push/i_push_data  write one entry
//   i_pop          remove the head entry
//   o_pop_data     head entry (meaningful while o_count != 0)
//   o_count        number of stored entries
// Push and pop in the same cycle are allowed at any occupancy.
module fetch_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic [CW-1:0]    o_count
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_pop;
    logic             w_do_push;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_do_pop  = i_pop && (r_count != '0) && !i_flush;
    // When full, a simultaneous pop frees the slot being written.
    assign w_do_push = i_push && !i_flush && ((r_count < CW'(DEPTH)) || w_do_pop);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_pop_data = r_mem[r_rd_ptr];
    assign o_count    = r_count;
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, reads the synchronous
// instruction memory and streams {pc, instr} to decode through fetch_fifo.
// Ports:
//   clock, reset  clock and asynchronous active-high reset
//   start         one-cycle pulse; in IDLE begins fetching at PC 0
//   halted        fetch stopped on the all-zero instruction word
//   bus           instr_fetch_unit_if.master: imem read port, output
//                 valid/ready stream, redirect request
module instr_fetch_unit
    import core_pkg::*;
#(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    output logic                halted,
    instr_fetch_unit_if.master  bus
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int FW = ADDR_W + DATA_W;

    fetch_state_t      r_state;
    fetch_state_t      w_state_next;
    logic [ADDR_W-1:0] r_pc;
    logic              r_inflight_p1;
    logic [ADDR_W-1:0] r_rsp_pc_p1;

    logic [CW-1:0]     w_count;
    logic [CW:0]       w_occupancy;
    logic [FW-1:0]     w_fifo_head;
    logic              w_issue;
    logic              w_rsp_zero;
    logic              w_push;
    logic              w_pop;
    logic              w_valid;

    // Issue stage: request a word only if its response is guaranteed a slot.
    assign w_occupancy = {1'b0, w_count} + {{CW{1'b0}}, r_inflight_p1};
    assign w_issue     = (r_state == RUN) && (w_occupancy < (CW + 1)'(FIFO_DEPTH));

    // Response stage: the redirect squashes the returning word; words that
    // arrive after the halt (issued alongside the zero word) are dropped.
    assign w_rsp_zero = r_inflight_p1 && (bus.imem_rdata == DATA_W'(HALT_WORD));
    assign w_push     = r_inflight_p1 && !w_rsp_zero && (r_state == RUN)
                        && !bus.redirect_valid;

    assign w_valid = (w_count != '0);
    assign w_pop   = w_valid && bus.out_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (bus.redirect_valid) begin
            w_state_next = RUN;
        end else begin
            case (r_state)
                IDLE:    if (start) w_state_next = RUN;
                RUN:     if (w_rsp_zero) w_state_next = HALT;
                default: w_state_next = r_state;
            endcase
        end
    end

    // A memory read may still be strobed in the redirect cycle (imem_en is
    // purely registered); clearing the in-flight flag discards its result.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc          <= '0;
            r_inflight_p1 <= 1'b0;
        end else if (bus.redirect_valid) begin
            r_pc          <= bus.redirect_pc;
            r_inflight_p1 <= 1'b0;
        end else begin
            r_inflight_p1 <= w_issue;
            if ((r_state == IDLE) && start) r_pc <= '0;
            else if (w_issue)               r_pc <= r_pc + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (w_issue) r_rsp_pc_p1 <= r_pc;
    end

    fetch_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .i_flush     (bus.redirect_valid),
        .i_push      (w_push),
        .i_push_data ({r_rsp_pc_p1, bus.imem_rdata}),
        .i_pop       (w_pop),
        .o_pop_data  (w_fifo_head),
        .o_count     (w_count)
    );

    // Outputs are forced to zero while empty so the idle/reset values are
    // defined without resetting the FIFO storage.
    assign bus.imem_en   = w_issue;
    assign bus.imem_addr = r_pc;
    assign bus.out_valid = w_valid;
    assign bus.out_pc    = w_valid ? w_fifo_head[FW-1:DATA_W] : '0;
    assign bus.out_instr = w_valid ? w_fifo_head[DATA_W-1:0] : '0;
    assign halted        = (r_state == HALT);
endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
    logic clock;
    logic reset;
    logic start;
    logic halted;

    instr_fetch_unit_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    instr_fetch_unit #(.ADDR_W(5), .DATA_W(32), .FIFO_DEPTH(4)) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .halted (halted),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous instruction memory model: data valid the cycle after the request.
    logic [31:0] imem [32];
    always_ff @(posedge clock) begin
        if (bus.imem_en) bus.imem_rdata <= imem[bus.imem_addr];
    end

    typedef struct {
        logic       ready;
        logic       valid;
        logic [4:0] pc;
        logic       en;
        logic       halted;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] prog [11];
    int          n_pass;
    int          n_total;
    int          got_pc[$];
    logic [31:0] got_instr[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " out_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, " out_instr"}, 64'(bus.out_instr), 64'd0);
        chk({tag, " out_pc"},    64'(bus.out_pc),    64'd0);
        chk({tag, " imem_en"},   64'(bus.imem_en),   64'd0);
        chk({tag, " imem_addr"}, 64'(bus.imem_addr), 64'd0);
        chk({tag, " halted"},    64'(halted),        64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        bus.out_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        @(negedge clock);
        chk_reset_outputs("reset");
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic load_prog();
        for (int i = 0; i < 32; i++) imem[i] = 32'h0;
        for (int i = 0; i < 11; i++) imem[i] = prog[i];
    endtask

    // Returns at the falling edge right after the edge that samples start.
    task automatic do_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic run_table(input string tag);
        logic [31:0] exp_instr;
        for (int k = 0; k < tbl.size(); k++) begin
            bus.out_ready = tbl[k].ready;
            exp_instr = tbl[k].valid ? imem[tbl[k].pc] : 32'h0;
            chk($sformatf("%s k=%0d out_valid", tag, k), 64'(bus.out_valid), 64'(tbl[k].valid));
            chk($sformatf("%s k=%0d out_pc", tag, k),    64'(bus.out_pc),    64'(tbl[k].valid ? tbl[k].pc : 5'd0));
            chk($sformatf("%s k=%0d out_instr", tag, k), 64'(bus.out_instr), 64'(exp_instr));
            chk($sformatf("%s k=%0d imem_en", tag, k),   64'(bus.imem_en),   64'(tbl[k].en));
            chk($sformatf("%s k=%0d halted", tag, k),    64'(halted),        64'(tbl[k].halted));
            @(negedge clock);
        end
    endtask

    task automatic collect(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            if (bus.out_valid && bus.out_ready) begin
                got_pc.push_back(int'(bus.out_pc));
                got_instr.push_back(bus.out_instr);
            end
            @(negedge clock);
        end
    endtask

    task automatic chk_seq(input string tag, input int exp_pcs[$]);
        chk({tag, " count"}, 64'(got_pc.size()), 64'(exp_pcs.size()));
        for (int i = 0; i < exp_pcs.size() && i < got_pc.size(); i++) begin
            chk($sformatf("%s pc[%0d]", tag, i),    64'(got_pc[i]),    64'(exp_pcs[i]));
            chk($sformatf("%s instr[%0d]", tag, i), 64'(got_instr[i]), 64'(imem[exp_pcs[i] % 32]));
        end
    endtask

    initial begin
        vec_t v;
        int   exp_pcs[$];
        logic found;
        logic saw_halt;

        n_pass  = 0;
        n_total = 0;
        prog[0]  = 32'h20010000;  // addi r1, r0, 0   (sum)
        prog[1]  = 32'h20020004;  // addi r2, r0, 4   (length)
        prog[2]  = 32'h20030000;  // addi r3, r0, 0   (index)
        prog[3]  = 32'h8C640000;  // lw   r4, 0(r3)
        prog[4]  = 32'h8C650010;  // lw   r5, 16(r3)
        prog[5]  = 32'h00853018;  // mult r6, r4, r5
        prog[6]  = 32'h00260820;  // add  r1, r1, r6
        prog[7]  = 32'h20630001;  // addi r3, r3, 1
        prog[8]  = 32'h1462FFFA;  // bne  r3, r2, -6
        prog[9]  = 32'hAC010020;  // sw   r1, 32(r0)
        prog[10] = 32'h00000000;  // end of program

        // 1: straight-line run at full rate, stops on word 10.
        do_reset();
        load_prog();
        tbl.delete();
        for (int k = 0; k < 14; k++) begin
            v.ready  = 1'b1;
            v.valid  = (k >= 2) && (k <= 11);
            v.pc     = v.valid ? 5'(k - 2) : 5'd0;
            v.en     = (k <= 11);
            v.halted = (k >= 12);
            tbl.push_back(v);
        end
        do_start();
        run_table("t1");

        // 2: consumer stalls 10 cycles; issue stops at 4 outstanding.
        do_reset();
        load_prog();
        tbl.delete();
        for (int k = 0; k < 21; k++) begin
            v.ready  = (k >= 10);
            v.valid  = (k >= 2) && (k <= 19);
            v.pc     = !v.valid ? 5'd0 : (k <= 10) ? 5'd0 : 5'(k - 10);
            v.en     = (k <= 3) || ((k >= 11) && (k <= 18));
            v.halted = (k >= 19);
            tbl.push_back(v);
        end
        do_start();
        run_table("t2");

        // 3: redirect to pc 1 while pc 9 is held at the output.
        do_reset();
        load_prog();
        do_start();
        bus.out_ready = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            if (bus.out_valid && bus.out_pc == 5'd9) found = 1'b1;
            else @(negedge clock);
        end
        chk("t3 reached pc9", 64'(found), 64'd1);
        bus.out_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 5'd1;
        @(negedge clock);
        bus.redirect_valid = 1'b0;
        chk("t3 valid after redirect", 64'(bus.out_valid), 64'd0);
        chk("t3 imem_en after redirect", 64'(bus.imem_en), 64'd1);
        chk("t3 imem_addr after redirect", 64'(bus.imem_addr), 64'd1);
        chk("t3 halted after redirect", 64'(halted), 64'd0);
        bus.out_ready = 1'b1;
        got_pc.delete();
        got_instr.delete();
        collect(30);
        exp_pcs = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        chk_seq("t3", exp_pcs);
        chk("t3 halted", 64'(halted), 64'd1);

        // 4: redirect coincides with the pc 4 transfer.
        do_reset();
        load_prog();
        do_start();
        bus.out_ready = 1'b1;
        got_pc.delete();
        got_instr.delete();
        found = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (bus.out_valid) begin
                got_pc.push_back(int'(bus.out_pc));
                got_instr.push_back(bus.out_instr);
            end
            if (!found && bus.out_valid && bus.out_pc == 5'd4) begin
                found = 1'b1;
                bus.redirect_valid = 1'b1;
                bus.redirect_pc = 5'd7;
                @(negedge clock);
                bus.redirect_valid = 1'b0;
                chk("t4 valid after redirect", 64'(bus.out_valid), 64'd0);
            end else begin
                @(negedge clock);
            end
        end
        chk("t4 reached pc4", 64'(found), 64'd1);
        exp_pcs = '{0, 1, 2, 3, 4, 7, 8, 9};
        chk_seq("t4", exp_pcs);
        chk("t4 halted", 64'(halted), 64'd1);

        // 5: asynchronous reset with the FIFO full.
        do_reset();
        load_prog();
        do_start();
        repeat (5) @(negedge clock);
        chk("t5 valid before reset", 64'(bus.out_valid), 64'd1);
        reset = 1'b1;
        #1;
        chk_reset_outputs("t5 async");
        @(negedge clock);
        reset = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            chk($sformatf("t5 idle c=%0d out_valid", c), 64'(bus.out_valid), 64'd0);
            chk($sformatf("t5 idle c=%0d imem_en", c),   64'(bus.imem_en),   64'd0);
        end
        do_start();
        repeat (2) @(negedge clock);
        chk("t5 restart valid", 64'(bus.out_valid), 64'd1);
        chk("t5 restart pc", 64'(bus.out_pc), 64'd0);

        // 6: no zero word anywhere; PC wraps 31 -> 0.
        do_reset();
        for (int i = 0; i < 32; i++) imem[i] = 32'hA0000000 | 32'(i);
        do_start();
        bus.out_ready = 1'b1;
        got_pc.delete();
        got_instr.delete();
        saw_halt = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (halted) saw_halt = 1'b1;
            if (bus.out_valid) begin
                got_pc.push_back(int'(bus.out_pc));
                got_instr.push_back(bus.out_instr);
            end
            @(negedge clock);
        end
        exp_pcs.delete();
        for (int i = 0; i < 38; i++) exp_pcs.push_back(i % 32);
        chk_seq("t6", exp_pcs);
        chk("t6 never halted", 64'(saw_halt), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
